// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by a 16x oversampling tick.
// Two-flop line synchroniser, start-bit validation at mid-bit, mid-bit data
// sampling LSB-first, stop-bit check, and a valid/rd holding register with
// sticky overrun and frame-error flags.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int OS_RATE   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rx,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 overrun,
  output logic                 frame_err
);

  localparam int TCW = $clog2(OS_RATE);
  localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TCW-1:0] HALF_M1  = TCW'(OS_RATE/2 - 1);
  localparam logic [TCW-1:0] FULL_M1  = TCW'(OS_RATE - 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t               state, state_nx;
  logic [TCW-1:0]       tick_cnt, tick_nx;
  logic [BCW-1:0]       bit_cnt, bit_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 sync_a, rx_s;
  logic                 load, ferr_set;

  // Two-flop synchroniser; idles high so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_a <= rx;
      rx_s   <= sync_a;
    end
  end

  // Receiver state and counters; all next values come from the comb block.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_nx;
      tick_cnt <= tick_nx;
      bit_cnt  <= bit_nx;
      shreg    <= shreg_nx;
    end
  end

  // Next-state logic; nothing moves except on an oversampling tick.
  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    bit_nx   = bit_cnt;
    shreg_nx = shreg;
    load     = 1'b0;
    ferr_set = 1'b0;
    if (rx_tick) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nx = START;
            tick_nx  = '0;
          end
        end
        START: begin
          if (tick_cnt == HALF_M1) begin
            // Still low at mid start bit: a real start, else a glitch.
            tick_nx  = '0;
            bit_nx   = '0;
            state_nx = rx_s ? IDLE : DATA;
          end else begin
            tick_nx = tick_cnt + TCW'(1);
          end
        end
        DATA: begin
          if (tick_cnt == FULL_M1) begin
            tick_nx  = '0;
            shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_cnt == LAST_BIT) state_nx = STOP;
            else                     bit_nx   = bit_cnt + BCW'(1);
          end else begin
            tick_nx = tick_cnt + TCW'(1);
          end
        end
        STOP: begin
          if (tick_cnt == FULL_M1) begin
            tick_nx = '0;
            if (rx_s) begin
              load     = 1'b1;
              state_nx = IDLE;
            end else begin
              ferr_set = 1'b1;
              state_nx = BRK;
            end
          end else begin
            tick_nx = tick_cnt + TCW'(1);
          end
        end
        BRK: begin
          // Wait for the line to return high so a held break cannot retrigger.
          if (rx_s) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Consumer-side holding register; a load or flag set beats a same-cycle rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rd) begin
        valid     <= 1'b0;
        overrun   <= 1'b0;
        frame_err <= 1'b0;
      end
      if (load) begin
        data  <= shreg;
        valid <= 1'b1;
        if (valid && !rd) overrun <= 1'b1;
      end
      if (ferr_set) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx; expected bytes go into a queue at
// stimulus time and a monitor pops and compares whenever a new byte appears.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_tick = 1'b0;
  logic       rx = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid, overrun, frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit fast = 1'b0;
  int tcnt = 0;

  logic [8:0] exp_q[$];   // {expected overrun, expected byte}

  uart_rx #(.DATA_BITS(8), .OS_RATE(16)) dut (
    .clk(clk), .rst(rst), .rx_tick(rx_tick), .rx(rx), .rd(rd),
    .data(data), .valid(valid), .overrun(overrun), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Tick source: every clk in fast mode, otherwise one pulse per 14 clk.
  always @(negedge clk) begin
    if (fast) begin
      rx_tick = 1'b1;
    end else begin
      tcnt    = (tcnt == 13) ? 0 : tcnt + 1;
      rx_tick = (tcnt == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a new byte is valid rising, or data changing while valid stays up.
  logic       mv_q = 1'b0;
  logic [7:0] md_q = 8'h00;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && valid && (!mv_q || data != md_q)) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_byte: got %0h expected none at %0t", data, $time);
      end else begin
        e = exp_q.pop_front();
        chk("mon_data", 32'(data), 32'(e[7:0]));
        chk("mon_overrun", 32'(overrun), 32'(e[8]));
      end
    end
    mv_q = valid;
    md_q = data;
  end

  // Start, 8 data bits LSB-first, stop; leaves the stop level on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bclk);
    rx = 1'b0;
    repeat (bclk) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (bclk) @(negedge clk);
    end
    rx = stop_bit;
    repeat (bclk) @(negedge clk);
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Short low glitch: rejected at the mid start-bit check.
    fast = 1'b1;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch_valid", 32'(valid), 32'h0);
    chk("glitch_frame_err", 32'(frame_err), 32'h0);
    chk("glitch_data", 32'(data), 32'h00);

    // 0x55 at 224 clk/bit with a tick every 14 clk.
    fast = 1'b0;
    exp_q.push_back({1'b0, 8'h55});
    send_frame(8'h55, 1'b1, 224);
    rx = 1'b1;
    repeat (448) @(negedge clk);
    chk("f55_valid", 32'(valid), 32'h1);
    chk("f55_data", 32'(data), 32'h55);
    chk("f55_frame_err", 32'(frame_err), 32'h0);
    chk("f55_overrun", 32'(overrun), 32'h0);
    pulse_rd();
    chk("f55_rd_valid", 32'(valid), 32'h0);

    // Two unread bytes: the second overwrites and raises overrun.
    fast = 1'b1;
    repeat (8) @(negedge clk);
    exp_q.push_back({1'b0, 8'hA3});
    send_frame(8'hA3, 1'b1, 16);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    exp_q.push_back({1'b1, 8'h0F});
    send_frame(8'h0F, 1'b1, 16);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    chk("ovr_valid", 32'(valid), 32'h1);
    chk("ovr_data", 32'(data), 32'h0F);
    chk("ovr_flag", 32'(overrun), 32'h1);
    pulse_rd();
    chk("ovr_rd_valid", 32'(valid), 32'h0);
    chk("ovr_rd_flag", 32'(overrun), 32'h0);

    // Bad stop bit followed by a 20-bit-time break, then a good frame.
    send_frame(8'h81, 1'b0, 16);
    repeat (20 * 16) @(negedge clk);
    chk("brk_frame_err", 32'(frame_err), 32'h1);
    chk("brk_valid", 32'(valid), 32'h0);
    chk("brk_data", 32'(data), 32'h0F);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    pulse_rd();
    chk("brk_rd_frame_err", 32'(frame_err), 32'h0);
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 1'b1, 16);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    chk("f3c_valid", 32'(valid), 32'h1);
    chk("f3c_data", 32'(data), 32'h3C);
    chk("f3c_frame_err", 32'(frame_err), 32'h0);

    // Reset in the middle of data bit 4 of 0xC7, then a clean 0xC7.
    rx = 1'b0;                               // start bit
    repeat (16) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (8'hC7 >> i) & 8'h01;
      repeat (16) @(negedge clk);
    end
    rx = 1'b0;                               // bit 4 of 0xC7
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_rst_data", 32'(data), 32'h00);
    chk("mid_rst_valid", 32'(valid), 32'h0);
    chk("mid_rst_flags", 32'({overrun, frame_err}), 32'h0);
    rst = 1'b0;
    rx = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_data", 32'(data), 32'h00);
    chk("post_rst_valid", 32'(valid), 32'h0);
    chk("post_rst_flags", 32'({overrun, frame_err}), 32'h0);
    exp_q.push_back({1'b0, 8'hC7});
    send_frame(8'hC7, 1'b1, 16);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    chk("fc7_valid", 32'(valid), 32'h1);
    chk("fc7_data", 32'(data), 32'hC7);
    chk("fc7_frame_err", 32'(frame_err), 32'h0);
    pulse_rd();

    // 0x12 left unread; rd lands on the exact clk where 0x34 loads.
    // Line falls before edge 0, rx_s low after edge 1, IDLE sees it on edge 2,
    // stop bit sampled 8 + 16*9 = 152 ticks later on edge 154.
    exp_q.push_back({1'b0, 8'h12});
    send_frame(8'h12, 1'b1, 16);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    exp_q.push_back({1'b0, 8'h34});
    fork
      send_frame(8'h34, 1'b1, 16);
      begin
        repeat (154) @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
      end
    join
    rx = 1'b1;
    repeat (32) @(negedge clk);
    chk("f34_valid", 32'(valid), 32'h1);
    chk("f34_data", 32'(data), 32'h34);
    chk("f34_overrun", 32'(overrun), 32'h0);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
